// File: rtl/integration_scheduler.sv
// Integration window scheduler: clear, time a programmable window, snapshot,
// then offer the frame to the transmitter; host command bytes steer it all.
module integration_scheduler #(
  parameter int unsigned PERIOD_WIDTH   = 32,
  parameter int unsigned DEFAULT_PERIOD = 400000,
  parameter int unsigned FRAME_ID_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cmd_valid,
  input  logic [7:0]                cmd_data,
  input  logic                      frame_ready,
  output logic                      counter_clear,
  output logic                      snapshot,
  output logic                      frame_valid,
  output logic [FRAME_ID_WIDTH-1:0] frame_id,
  output logic [3:0]                active_line,
  output logic                      overrun,
  output logic                      busy
);

  localparam logic [3:0] OP_SET_LINE = 4'd1;
  localparam logic [3:0] OP_NIBBLE   = 4'd4;
  localparam logic [3:0] OP_APPLY    = 4'd5;
  localparam logic [3:0] OP_SHOT     = 4'd6;
  localparam logic [3:0] OP_CLEAR_ST = 4'd7;
  localparam logic [3:0] OP_ENABLE   = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLEAR     = 2'd1,
    ST_INTEGRATE = 2'd2,
    ST_SNAP      = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic                      enable_q, enable_d;
  logic [PERIOD_WIDTH-1:0]   period_q, period_d;
  logic [PERIOD_WIDTH-1:0]   shadow_q, shadow_d;
  logic [PERIOD_WIDTH-1:0]   cnt_q, cnt_d;
  logic                      shot_pend_q, shot_pend_d;
  logic                      shot_run_q, shot_run_d;
  logic                      frame_valid_q, frame_valid_d;
  logic [FRAME_ID_WIDTH-1:0] frame_id_q, frame_id_d;
  logic [3:0]                line_q, line_d;
  logic                      overrun_q, overrun_d;
  logic                      counter_clear_q, counter_clear_d;
  logic                      snapshot_q, snapshot_d;
  logic                      busy_q, busy_d;

  logic [3:0] opcode;
  logic [3:0] arg;

  assign opcode = cmd_data[3:0];
  assign arg    = cmd_data[7:4];

  // Next-state, window timing, handshake and command decode
  always_comb begin
    state_d       = state_q;
    enable_d      = enable_q;
    period_d      = period_q;
    shadow_d      = shadow_q;
    cnt_d         = cnt_q;
    shot_pend_d   = shot_pend_q;
    shot_run_d    = shot_run_q;
    frame_valid_d = frame_valid_q;
    frame_id_d    = frame_id_q;
    line_d        = line_q;
    overrun_d     = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (enable_q || shot_pend_q) begin
          state_d     = ST_CLEAR;
          shot_run_d  = shot_pend_q;
          shot_pend_d = 1'b0;
        end
      end
      ST_CLEAR: begin
        cnt_d   = period_q - PERIOD_WIDTH'(1);
        state_d = ST_INTEGRATE;
      end
      ST_INTEGRATE: begin
        if (cnt_q == '0) begin
          state_d = ST_SNAP;
        end else begin
          cnt_d = cnt_q - PERIOD_WIDTH'(1);
        end
      end
      ST_SNAP: begin
        // Newest frame wins; an unaccepted older frame is flagged as overrun
        if (frame_valid_q && !frame_ready) begin
          overrun_d = 1'b1;
        end
        frame_valid_d = 1'b1;
        frame_id_d    = frame_id_q + FRAME_ID_WIDTH'(1);
        state_d       = (enable_q && !shot_run_q) ? ST_CLEAR : ST_IDLE;
        shot_run_d    = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_SNAP) && frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end

    if (cmd_valid) begin
      case (opcode)
        OP_SET_LINE: line_d = arg;
        OP_NIBBLE:   shadow_d = {shadow_q[PERIOD_WIDTH-5:0], arg};
        OP_APPLY: begin
          period_d = (shadow_q == '0) ? PERIOD_WIDTH'(1) : shadow_q;
          shadow_d = '0;
        end
        OP_SHOT: begin
          if ((state_q == ST_IDLE) && !enable_q && !shot_pend_q) begin
            shot_pend_d = 1'b1;
          end
        end
        OP_CLEAR_ST: overrun_d = 1'b0;
        OP_ENABLE:   enable_d = arg[0];
        default: ;
      endcase
    end

    counter_clear_d = (state_d == ST_CLEAR);
    snapshot_d      = (state_d == ST_SNAP);
    busy_d          = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      enable_q        <= 1'b0;
      period_q        <= PERIOD_WIDTH'(DEFAULT_PERIOD);
      shadow_q        <= '0;
      cnt_q           <= '0;
      shot_pend_q     <= 1'b0;
      shot_run_q      <= 1'b0;
      frame_valid_q   <= 1'b0;
      frame_id_q      <= '0;
      line_q          <= '0;
      overrun_q       <= 1'b0;
      counter_clear_q <= 1'b0;
      snapshot_q      <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      enable_q        <= enable_d;
      period_q        <= period_d;
      shadow_q        <= shadow_d;
      cnt_q           <= cnt_d;
      shot_pend_q     <= shot_pend_d;
      shot_run_q      <= shot_run_d;
      frame_valid_q   <= frame_valid_d;
      frame_id_q      <= frame_id_d;
      line_q          <= line_d;
      overrun_q       <= overrun_d;
      counter_clear_q <= counter_clear_d;
      snapshot_q      <= snapshot_d;
      busy_q          <= busy_d;
    end
  end

  assign counter_clear = counter_clear_q;
  assign snapshot      = snapshot_q;
  assign frame_valid   = frame_valid_q;
  assign frame_id      = frame_id_q;
  assign active_line   = line_q;
  assign overrun       = overrun_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_integration_scheduler.sv
// Bench for integration_scheduler: event-time model of the window schedule
// compared every cycle, plus directed scenarios with literal expectations.
module tb_integration_scheduler;

  localparam int unsigned PW  = 32;
  localparam int unsigned FW  = 32;
  localparam int unsigned DEF = 20;
  localparam longint NEVER = 64'sh3fff_ffff_ffff_ffff;

  localparam logic [3:0] OP_LINE  = 4'd1;
  localparam logic [3:0] OP_NIB   = 4'd4;
  localparam logic [3:0] OP_APPLY = 4'd5;
  localparam logic [3:0] OP_SHOT  = 4'd6;
  localparam logic [3:0] OP_CLR   = 4'd7;
  localparam logic [3:0] OP_EN    = 4'd13;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic [7:0]    cmd_data;
  logic          frame_ready;
  logic          counter_clear;
  logic          snapshot;
  logic          frame_valid;
  logic [FW-1:0] frame_id;
  logic [3:0]    active_line;
  logic          overrun;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  integration_scheduler #(
    .PERIOD_WIDTH  (PW),
    .DEFAULT_PERIOD(DEF),
    .FRAME_ID_WIDTH(FW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_data     (cmd_data),
    .frame_ready  (frame_ready),
    .counter_clear(counter_clear),
    .snapshot     (snapshot),
    .frame_valid  (frame_valid),
    .frame_id     (frame_id),
    .active_line  (active_line),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: windows tracked as absolute cycle numbers of their CLEAR and SNAP
  longint        cyc = 0;
  longint        m_start = -10;
  longint        m_snap = -10;
  bit            m_enable, m_shot_pend, m_shot_run, m_fvalid, m_overrun;
  logic [PW-1:0] m_period, m_shadow;
  logic [FW-1:0] m_fid;
  logic [3:0]    m_line;
  bit            e_clear, e_snap, e_busy;

  always @(posedge clk) begin
    longint cur;
    longint nxt;
    bit busy_now, is_clear, is_snap, en_pre, pend_pre;
    cur = cyc;
    if (!reset_n) begin
      m_start = -10; m_snap = -10;
      m_enable = 0; m_shot_pend = 0; m_shot_run = 0;
      m_fvalid = 0; m_overrun = 0;
      m_period = PW'(DEF); m_shadow = '0; m_fid = '0; m_line = '0;
    end else begin
      busy_now = (m_start <= cur) && (cur <= m_snap);
      is_clear = (cur == m_start);
      is_snap  = (cur == m_snap);
      en_pre   = m_enable;
      pend_pre = m_shot_pend;
      if (is_clear) begin
        m_snap = cur + longint'(m_period) + 1;
      end else if (is_snap) begin
        if (m_fvalid && !frame_ready) m_overrun = 1;
        m_fid = m_fid + 1;
        if (en_pre && !m_shot_run) begin
          m_start = cur + 1;
          m_snap  = NEVER;
        end
        m_shot_run = 0;
      end else if (!busy_now && (en_pre || pend_pre)) begin
        m_start     = cur + 1;
        m_snap      = NEVER;
        m_shot_run  = pend_pre;
        m_shot_pend = 0;
      end
      if (is_snap) m_fvalid = 1;
      else if (m_fvalid && frame_ready) m_fvalid = 0;
      if (cmd_valid) begin
        case (cmd_data[3:0])
          OP_LINE:  m_line = cmd_data[7:4];
          OP_NIB:   m_shadow = (m_shadow << 4) | PW'(cmd_data[7:4]);
          OP_APPLY: begin
            m_period = (m_shadow == '0) ? PW'(1) : m_shadow;
            m_shadow = '0;
          end
          OP_SHOT:  if (!busy_now && !en_pre && !pend_pre) m_shot_pend = 1;
          OP_CLR:   m_overrun = 0;
          OP_EN:    m_enable = cmd_data[4];
          default: ;
        endcase
      end
    end
    nxt     = cur + 1;
    e_clear = (nxt == m_start);
    e_snap  = (nxt == m_snap);
    e_busy  = (m_start <= nxt) && (nxt <= m_snap);
    cyc     = cyc + 1;
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("model_counter_clear", 32'(counter_clear), 32'(e_clear));
      check("model_snapshot", 32'(snapshot), 32'(e_snap));
      check("model_busy", 32'(busy), 32'(e_busy));
      check("model_frame_valid", 32'(frame_valid), 32'(m_fvalid));
      check("model_frame_id", frame_id, m_fid);
      check("model_active_line", 32'(active_line), 32'(m_line));
      check("model_overrun", 32'(overrun), 32'(m_overrun));
    end
  end

  task automatic send_cmd(input logic [3:0] op, input logic [3:0] arg);
    cmd_valid = 1'b1;
    cmd_data  = {arg, op};
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
  endtask

  function automatic bit sig_now(input int which);
    case (which)
      0:       return snapshot === 1'b1;
      1:       return counter_clear === 1'b1;
      default: return busy === 1'b0;
    endcase
  endfunction

  // Steps at least one cycle, returns cycles until the event (0 snap, 1 clear, 2 idle)
  task automatic wait_next(input int which, input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig_now(which) && n < max);
    if (!sig_now(which)) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_event_%0d: no event within %0d cycles", which, max);
    end
  endtask

  initial begin
    int n;
    int clears;
    reset_n     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_data    = 8'h00;
    frame_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    check("reset_busy", 32'(busy), 0);
    check("reset_frame_id", frame_id, 0);
    check("reset_counter_clear", 32'(counter_clear), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Continuous capture, period 3, ready tied high
    send_cmd(OP_NIB, 4'h3);
    send_cmd(OP_APPLY, 4'h0);
    send_cmd(OP_EN, 4'h1);
    wait_next(0, 50, n);
    wait_next(0, 20, n);
    check("p3_interval_a", 32'(n), 5);
    wait_next(0, 20, n);
    check("p3_interval_b", 32'(n), 5);
    @(negedge clk);
    check("p3_frame_id", frame_id, 3);
    check("p3_valid_on", 32'(frame_valid), 1);
    @(negedge clk);
    check("p3_valid_pulse", 32'(frame_valid), 0);

    // Period 16 applied during a period-3 window
    wait_next(0, 20, n);
    send_cmd(OP_NIB, 4'h1);
    send_cmd(OP_NIB, 4'h0);
    send_cmd(OP_APPLY, 4'h0);
    wait_next(0, 20, n);
    check("apply_old_window", 32'(n), 2);
    wait_next(0, 40, n);
    check("apply_new_window", 32'(n), 18);

    // Disable: in-flight window drains, then single shot of period 10
    send_cmd(OP_EN, 4'h0);
    wait_next(2, 40, n);
    check("disable_drain", 32'(n), 18);
    send_cmd(OP_NIB, 4'hA);
    send_cmd(OP_APPLY, 4'h0);
    send_cmd(OP_SHOT, 4'h0);
    wait_next(1, 10, n);
    check("shot_clear_latency", 32'(n), 1);
    send_cmd(OP_SHOT, 4'h0);
    wait_next(0, 20, n);
    check("shot_window", 32'(n + 1), 11);
    wait_next(2, 5, n);
    check("shot_idle", 32'(n), 1);
    clears = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (counter_clear === 1'b1) clears++;
    end
    check("shot_runs_once", 32'(clears), 0);

    // Overrun with transmitter stalled, period 2
    frame_ready = 1'b0;
    send_cmd(OP_NIB, 4'h2);
    send_cmd(OP_APPLY, 4'h0);
    send_cmd(OP_EN, 4'h1);
    wait_next(0, 20, n);
    wait_next(0, 20, n);
    check("p2_interval", 32'(n), 4);
    @(negedge clk);
    check("overrun_set", 32'(overrun), 1);
    check("overrun_valid_held", 32'(frame_valid), 1);
    check("overrun_frame_id", frame_id, 10);
    send_cmd(OP_EN, 4'h0);
    wait_next(2, 20, n);
    frame_ready = 1'b1;
    @(negedge clk);
    check("ready_drops_valid", 32'(frame_valid), 0);
    send_cmd(OP_CLR, 4'h0);
    check("clear_status", 32'(overrun), 0);

    // Ready asserted exactly in a SNAP cycle while a frame is pending
    frame_ready = 1'b0;
    send_cmd(OP_EN, 4'h1);
    wait_next(0, 20, n);
    wait_next(0, 20, n);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    check("snap_ready_no_overrun", 32'(overrun), 0);
    check("snap_ready_valid", 32'(frame_valid), 1);
    check("snap_ready_frame_id", frame_id, 13);
    frame_ready = 1'b1;
    send_cmd(OP_EN, 4'h0);
    wait_next(2, 20, n);

    // Reset mid-window with a frame pending
    frame_ready = 1'b0;
    send_cmd(OP_LINE, 4'h5);
    send_cmd(OP_NIB, 4'hA);
    send_cmd(OP_APPLY, 4'h0);
    send_cmd(OP_EN, 4'h1);
    wait_next(0, 30, n);
    repeat (3) @(negedge clk);
    check("pre_reset_valid", 32'(frame_valid), 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_counter_clear", 32'(counter_clear), 0);
    check("rst_snapshot", 32'(snapshot), 0);
    check("rst_frame_valid", 32'(frame_valid), 0);
    check("rst_frame_id", frame_id, 0);
    check("rst_active_line", 32'(active_line), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;
    send_cmd(OP_LINE, 4'h9);
    check("active_line_9", 32'(active_line), 9);
    frame_ready = 1'b1;
    send_cmd(OP_EN, 4'h1);
    wait_next(0, 100, n);
    wait_next(0, 100, n);
    check("default_period", 32'(n), DEF + 2);
    @(negedge clk);
    check("post_reset_frame_id", frame_id, 2);
    send_cmd(OP_EN, 4'h0);
    wait_next(2, 40, n);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
